// File: rtl/rt_imp_mac_pkg.sv
// rt_imp_mac_pkg: shared tag type and multiplier geometry for the MAC accumulate stage
package rt_imp_mac_pkg;
  localparam int MUL_A_W = 12;
  localparam int MUL_B_W = 12;
  localparam int MUL_P_W = 24;
  localparam int DEF_MUL_LAT = 4;
  typedef struct packed {
    logic v;
    logic last;
  } tag_t;
endpackage

// File: rtl/rt_imp_mac_tag_pipe.sv
// rt_imp_mac_tag_pipe: ce-enabled valid/last shift register tracking the multiplier latency
module rt_imp_mac_tag_pipe
  import rt_imp_mac_pkg::*;
#(
  parameter int DEPTH = DEF_MUL_LAT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ce,
  input  tag_t d,
  output tag_t q
);
  tag_t [DEPTH-1:0] sr;
  // advance tags in lockstep with the multiplier pipeline
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sr <= '0;
    else if (ce) sr <= {sr[DEPTH-2:0], d};
  assign q = sr[DEPTH-1];
endmodule

// File: rtl/rt_imp_mac_accum_stage.sv
// rt_imp_mac_accum_stage: per-frame MAC accumulation around a 4-cycle multiplier; RT_IMP_MAC_SAT_EN selects saturation
module rt_imp_mac_accum_stage
  import rt_imp_mac_pkg::*;
#(
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int ACC_W = 32,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [MUL_A_W-1:0] s_a,
  input  logic [MUL_B_W-1:0] s_b,
  input  logic               s_last,
  output logic               mul_ce,
  output logic [MUL_A_W-1:0] mul_din0,
  output logic [MUL_B_W-1:0] mul_din1,
  input  logic [MUL_P_W-1:0] mul_dout,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [ACC_W-1:0]   m_sum,
  output logic [CNT_W-1:0]   m_count,
  output logic               m_ovf
);
  logic [1:0] rst_sync;
  logic rst_n, stall, take, carry, ovf_flag, ovf_next;
  logic [ACC_W-1:0] acc, sum_raw, sum_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  tag_t tag_in, tail;
  // async assert, sync deassert of the internal reset
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) rst_sync <= '0;
    else rst_sync <= {rst_sync[0], 1'b1};
  assign rst_n = rst_sync[1];
  assign stall = m_valid & ~m_ready;
  assign mul_ce = ~stall;
  assign s_ready = ~stall;
  assign mul_din0 = s_a;
  assign mul_din1 = s_b;
  assign tag_in = {s_valid & s_ready, s_valid & s_ready & s_last};
  rt_imp_mac_tag_pipe #(.DEPTH(MUL_LAT)) u_tags (
    .clk(clk), .rst_n(rst_n), .ce(mul_ce), .d(tag_in), .q(tail)
  );
  assign take = mul_ce & tail.v;
  assign {carry, sum_raw} = {1'b0, acc} + (ACC_W+1)'(mul_dout);
`ifdef RT_IMP_MAC_SAT_EN
  assign sum_next = (carry | ovf_flag) ? '1 : sum_raw;
`else
  assign sum_next = sum_raw;
`endif
  assign cnt_next = cnt + CNT_W'(1);
  assign ovf_next = ovf_flag | carry;
  // accumulate tail products; a tail last publishes the frame and restarts the accumulator
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      ovf_flag <= 1'b0;
      m_valid <= 1'b0;
      m_sum <= '0;
      m_count <= '0;
      m_ovf <= 1'b0;
    end else if (take & tail.last) begin
      m_sum <= sum_next;
      m_count <= cnt_next;
      m_ovf <= ovf_next;
      m_valid <= 1'b1;
      acc <= '0;
      cnt <= '0;
      ovf_flag <= 1'b0;
    end else begin
      if (take) begin
        acc <= sum_next;
        cnt <= cnt_next;
        ovf_flag <= ovf_next;
      end
      if (m_valid & m_ready) m_valid <= 1'b0;
    end
endmodule

// File: tb/tb_rt_imp_mac_accum_stage.sv
// tb_rt_imp_mac_accum_stage: scoreboard bench for the MAC accumulate stage with a behavioural multiplier
module tb_rt_imp_mac_accum_stage;
  logic clk = 0, reset_n = 1;
  logic s_valid, s_last, m_ready, en24;
  logic [11:0] s_a, s_b;
  logic s_ready, mul_ce, m_valid, m_ovf;
  logic [11:0] mul_din0, mul_din1;
  logic [23:0] mul_dout;
  logic [31:0] m_sum;
  logic [15:0] m_count;
  logic s_ready24, mul_ce24, m_valid24, m_ovf24;
  logic [11:0] mul_din0_24, mul_din1_24;
  logic [23:0] mul_dout24, m_sum24;
  logic [15:0] m_count24;
  logic [23:0] p [4];
  logic [23:0] p24 [4];
  int vectors = 0, miscompares = 0;
  typedef struct {logic [31:0] sum; logic [15:0] cnt; logic ovf;} exp_t;
  exp_t q[$], q24[$];

  always #5 clk = ~clk;

  rt_imp_mac_accum_stage dut (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
    .s_last(s_last), .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
    .m_valid(m_valid), .m_ready(m_ready), .m_sum(m_sum), .m_count(m_count), .m_ovf(m_ovf)
  );

  rt_imp_mac_accum_stage #(.ACC_W(24)) dut24 (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid & en24), .s_ready(s_ready24), .s_a(s_a), .s_b(s_b),
    .s_last(s_last), .mul_ce(mul_ce24), .mul_din0(mul_din0_24), .mul_din1(mul_din1_24),
    .mul_dout(mul_dout24), .m_valid(m_valid24), .m_ready(1'b1), .m_sum(m_sum24),
    .m_count(m_count24), .m_ovf(m_ovf24)
  );

  always @(posedge clk) if (mul_ce) begin
    p[0] <= 24'(mul_din0) * 24'(mul_din1);
    for (int i = 1; i < 4; i++) p[i] <= p[i-1];
  end
  assign mul_dout = p[3];

  always @(posedge clk) if (mul_ce24) begin
    p24[0] <= 24'(mul_din0_24) * 24'(mul_din1_24);
    for (int i = 1; i < 4; i++) p24[i] <= p24[i-1];
  end
  assign mul_dout24 = p24[3];

  always @(negedge clk) begin : mon
    exp_t e;
    if (m_valid && m_ready) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_sum: got sum=0x%0h count=%0d ovf=%0b, expected no output", m_sum, m_count, m_ovf);
      end else begin
        e = q.pop_front();
        if (m_sum !== e.sum || m_count !== e.cnt || m_ovf !== e.ovf) begin
          miscompares++;
          $display("FAIL frame_sum: got sum=0x%0h count=%0d ovf=%0b, expected sum=0x%0h count=%0d ovf=%0b",
                   m_sum, m_count, m_ovf, e.sum, e.cnt, e.ovf);
        end
      end
    end
  end

  always @(negedge clk) begin : mon24
    exp_t e;
    if (m_valid24) begin
      vectors++;
      if (q24.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_sum24: got sum=0x%0h count=%0d ovf=%0b, expected no output", m_sum24, m_count24, m_ovf24);
      end else begin
        e = q24.pop_front();
        if ({8'h0, m_sum24} !== e.sum || m_count24 !== e.cnt || m_ovf24 !== e.ovf) begin
          miscompares++;
          $display("FAIL frame_sum24: got sum=0x%0h count=%0d ovf=%0b, expected sum=0x%0h count=%0d ovf=%0b",
                   m_sum24, m_count24, m_ovf24, e.sum, e.cnt, e.ovf);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] s, input logic [15:0] c, input logic o);
    q.push_back('{s, c, o});
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [11:0] a, input logic [11:0] b, input logic last, output int waits);
    s_a = a; s_b = b; s_last = last; s_valid = 1; waits = 0;
    @(negedge clk);
    while (!s_ready && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    if (!s_ready) chk("s_ready_timeout", {31'h0, s_ready}, 32'h1);
    @(posedge clk);
    #1 s_valid = 0; s_last = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w, stalls, n;
    s_valid = 0; s_last = 0; s_a = 0; s_b = 0; m_ready = 1; en24 = 0;
    #2 reset_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_m_valid", {31'h0, m_valid}, 32'h0);
    chk("rst_m_sum", m_sum, 32'h0);
    chk("rst_m_count", {16'h0, m_count}, 32'h0);
    chk("rst_m_ovf", {31'h0, m_ovf}, 32'h0);
    chk("rst_s_ready", {31'h0, s_ready}, 32'h1);
    chk("rst_mul_ce", {31'h0, mul_ce}, 32'h1);
    @(negedge clk) reset_n = 1;
    idle(3);
    // three-pair frame
    push(32'd16789060, 16'd3, 1'b0);
    send(12'd5, 12'd7, 1'b0, w);
    send(12'd100, 12'd200, 1'b0, w);
    send(12'd4095, 12'd4095, 1'b1, w);
    idle(8);
    // continuous single-pair frames
    stalls = 0;
    for (int i = 1; i <= 10; i++) begin
      push(32'(i * i), 16'd1, 1'b0);
      send(12'(i), 12'(i), 1'b1, w);
      stalls += w;
    end
    chk("s_ready_held", 32'(stalls), 32'h0);
    idle(8);
    // output backpressure with a second frame in flight
    m_ready = 0;
    push(32'd14, 16'd2, 1'b0);
    push(32'd40, 16'd2, 1'b0);
    send(12'd1, 12'd2, 1'b0, w);
    send(12'd3, 12'd4, 1'b1, w);
    send(12'd6, 12'd6, 1'b0, w);
    send(12'd2, 12'd2, 1'b1, w);
    n = 0;
    while (!m_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid", {31'h0, m_valid}, 32'h1);
    repeat (3) begin
      @(negedge clk);
      chk("bp_s_ready", {31'h0, s_ready}, 32'h0);
      chk("bp_mul_ce", {31'h0, mul_ce}, 32'h0);
      chk("bp_held_sum", m_sum, 32'd14);
    end
    @(posedge clk);
    #1 m_ready = 1;
    idle(10);
    chk("bp_drained", 32'(q.size()), 32'h0);
    // bubbles mid-frame
    push(32'd68, 16'd3, 1'b0);
    send(12'd2, 12'd3, 1'b0, w);
    s_a = 12'd100; s_b = 12'd100;
    idle(2);
    send(12'd4, 12'd5, 1'b0, w);
    send(12'd6, 12'd7, 1'b1, w);
    idle(8);
    // accumulator overflow on the 24-bit instance
    en24 = 1;
    push(32'd33538050, 16'd2, 1'b0);
`ifdef RT_IMP_MAC_SAT_EN
    q24.push_back('{32'h00FF_FFFF, 16'd2, 1'b1});
`else
    q24.push_back('{32'h00FF_C002, 16'd2, 1'b1});
`endif
    send(12'd4095, 12'd4095, 1'b0, w);
    send(12'd4095, 12'd4095, 1'b1, w);
    idle(8);
    en24 = 0;
    // reset with a partial frame accumulated and pairs in flight
    send(12'd5, 12'd5, 1'b0, w);
    idle(5);
    send(12'd7, 12'd7, 1'b0, w);
    send(12'd8, 12'd8, 1'b1, w);
    reset_n = 0;
    @(negedge clk);
    chk("inrst_m_valid", {31'h0, m_valid}, 32'h0);
    @(posedge clk);
    #1 reset_n = 1;
    idle(10);
    push(32'd9, 16'd1, 1'b0);
    send(12'd3, 12'd3, 1'b1, w);
    n = 0;
    while ((q.size() != 0 || q24.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(q.size() + q24.size()), 32'h0);
    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
